// File: rtl/ht_padr_pipe.sv
// ---------------------------------------------------------------------------
// ht_padr_pipe
//
// Purpose
//   Two-stage physical-address former for the hash-table MMU. Takes the
//   result of a hash-table group probe, selects the hit way's PTE fields,
//   merges the PPN with the virtual page offset (three page sizes), checks
//   the requested access against the way's R/W/X permissions and returns
//   the physical address together with a fault code. Sits between the
//   hash-table probe and the TLB fill / LSU path.
//
// Ports
//   clk       in   1          clock
//   rst       in   1          synchronous reset, active low
//   flush     in   1          discard all in-flight requests
//   req_v     in   1          request valid
//   req_rdy   out  1          request accepted when req_v & req_rdy
//   xlat      in   1          1 = translate, 0 = bypass (padr = vadr)
//   found     in   1          hash probe hit
//   which     in   WW         hit way index
//   ppn_all   in   NWAY*PPNW  PPN of each way, way0 in LSBs
//   sz_all    in   NWAY*2     page-size code per way
//   perm_all  in   NWAY*3     {x,w,r} per way
//   acc       in   3          requested access {x,w,r}
//   vadr      in   VAW        virtual address
//   rsp_v     out  1          response valid
//   rsp_rdy   in   1          consumer ready
//   padr      out  PAW        physical address
//   padrv     out  1          padr usable (fault == 0)
//   fault     out  2          0 none, 1 miss, 2 permission, 3 bad size
//   miss_cnt  out  CNTW       saturating count of delivered miss responses
//
// Handshake
//   Both interfaces are valid/ready: a transfer happens on a rising edge
//   where valid & ready are both high. A producer holding valid keeps its
//   payload stable until the transfer; req_rdy is combinational from the
//   pipeline state and flush (no skid buffer), and the response payload
//   is held stable while rsp_v & !rsp_rdy.
// ---------------------------------------------------------------------------
module ht_padr_pipe #(
  parameter int VAW     = 32,
  parameter int PAW     = 32,
  parameter int PGSHIFT = 18,
  parameter int LGSTEP  = 4,
  parameter int NWAY    = 8,
  parameter int CNTW    = 16,
  localparam int PPNW   = PAW - PGSHIFT,
  localparam int WW     = (NWAY > 1) ? $clog2(NWAY) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 req_v,
  output logic                 req_rdy,
  input  logic                 xlat,
  input  logic                 found,
  input  logic [WW-1:0]        which,
  input  logic [NWAY*PPNW-1:0] ppn_all,
  input  logic [NWAY*2-1:0]    sz_all,
  input  logic [NWAY*3-1:0]    perm_all,
  input  logic [2:0]           acc,
  input  logic [VAW-1:0]       vadr,
  output logic                 rsp_v,
  input  logic                 rsp_rdy,
  output logic [PAW-1:0]       padr,
  output logic                 padrv,
  output logic [1:0]           fault,
  output logic [CNTW-1:0]      miss_cnt
);

  localparam logic [1:0] FLT_NONE = 2'd0;
  localparam logic [1:0] FLT_MISS = 2'd1;
  localparam logic [1:0] FLT_PERM = 2'd2;
  localparam logic [1:0] FLT_SIZE = 2'd3;

  // -------------------------------------------------------------------------
  // Low-offset mask for a page-size code: bit i is set when i < off, with
  // off = PGSHIFT + sz*LGSTEP. Bits past PAW simply never get set, so an
  // oversized offset degrades to "all offset".
  // -------------------------------------------------------------------------
  function automatic logic [PAW-1:0] low_mask(input logic [1:0] sz);
    logic [PAW-1:0] m;
    int             off;
    off = PGSHIFT + int'(sz) * LGSTEP;
    m   = '0;
    for (int i = 0; i < PAW; i++) begin
      m[i] = (i < off);
    end
    return m;
  endfunction

  // -------------------------------------------------------------------------
  // Pipeline control
  // -------------------------------------------------------------------------
  logic s1_v_q, s1_v_d;
  logic s2_v_q, s2_v_d;
  logic s2_adv;
  logic req_fire;
  logic rsp_fire;

  // S2 can take a new entry when it is empty or its entry leaves this cycle;
  // S1 moves only together with S2, so S1 is free when empty or S2 advances.
  assign s2_adv   = !s2_v_q || rsp_rdy;
  assign req_rdy  = !flush && (!s1_v_q || s2_adv);
  assign req_fire = req_v && req_rdy;
  assign rsp_fire = s2_v_q && rsp_rdy;

  // -------------------------------------------------------------------------
  // Way select. A which value that matches no way (only possible for a
  // non-power-of-2 NWAY) leaves way_ok low and is reported as a miss.
  // -------------------------------------------------------------------------
  logic [PPNW-1:0] sel_ppn;
  logic [1:0]      sel_sz;
  logic [2:0]      sel_perm;
  logic            way_ok;

  always_comb begin
    sel_ppn  = '0;
    sel_sz   = '0;
    sel_perm = '0;
    way_ok   = 1'b0;
    for (int i = 0; i < NWAY; i++) begin
      if (which == WW'(i)) begin
        sel_ppn  = ppn_all[i*PPNW +: PPNW];
        sel_sz   = sz_all[i*2 +: 2];
        sel_perm = perm_all[i*3 +: 3];
        way_ok   = 1'b1;
      end
    end
  end

  // Virtual address brought to the physical width (truncate or zero-extend).
  logic [PAW-1:0] vadr_ext;

  generate
    if (VAW >= PAW) begin : g_vtrunc
      assign vadr_ext = vadr[PAW-1:0];
    end else begin : g_vzext
      assign vadr_ext = {{(PAW-VAW){1'b0}}, vadr};
    end
  endgenerate

  // -------------------------------------------------------------------------
  // S1 registers: request plus the selected way's fields
  // -------------------------------------------------------------------------
  logic            s1_xlat_q, s1_xlat_d;
  logic            s1_hit_q,  s1_hit_d;
  logic [PPNW-1:0] s1_ppn_q,  s1_ppn_d;
  logic [1:0]      s1_sz_q,   s1_sz_d;
  logic [2:0]      s1_perm_q, s1_perm_d;
  logic [2:0]      s1_acc_q,  s1_acc_d;
  logic [PAW-1:0]  s1_vadr_q, s1_vadr_d;

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_xlat_d = s1_xlat_q;
    s1_hit_d  = s1_hit_q;
    s1_ppn_d  = s1_ppn_q;
    s1_sz_d   = s1_sz_q;
    s1_perm_d = s1_perm_q;
    s1_acc_d  = s1_acc_q;
    s1_vadr_d = s1_vadr_q;
    if (flush) begin
      s1_v_d = 1'b0;
    end else if (req_rdy) begin
      // S1 either refills or drains into S2 whenever it is allowed to move.
      s1_v_d = req_v;
      if (req_fire) begin
        s1_xlat_d = xlat;
        s1_hit_d  = found && way_ok;
        s1_ppn_d  = sel_ppn;
        s1_sz_d   = sel_sz;
        s1_perm_d = sel_perm;
        s1_acc_d  = acc;
        s1_vadr_d = vadr_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v_q    <= 1'b0;
      s1_xlat_q <= 1'b0;
      s1_hit_q  <= 1'b0;
      s1_ppn_q  <= '0;
      s1_sz_q   <= '0;
      s1_perm_q <= '0;
      s1_acc_q  <= '0;
      s1_vadr_q <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_xlat_q <= s1_xlat_d;
      s1_hit_q  <= s1_hit_d;
      s1_ppn_q  <= s1_ppn_d;
      s1_sz_q   <= s1_sz_d;
      s1_perm_q <= s1_perm_d;
      s1_acc_q  <= s1_acc_d;
      s1_vadr_q <= s1_vadr_d;
    end
  end

  // -------------------------------------------------------------------------
  // Address formation and fault classification from S1
  // -------------------------------------------------------------------------
  logic [PAW-1:0] off_mask;
  logic [PAW-1:0] ppn_base;
  logic [PAW-1:0] form_padr;
  logic [PAW-1:0] res_padr;
  logic [1:0]     res_fault;

  assign off_mask  = low_mask(s1_sz_q);
  assign ppn_base  = PAW'(s1_ppn_q) << PGSHIFT;
  // Large pages take their low PPN bits from the virtual offset instead.
  assign form_padr = (s1_vadr_q & off_mask) | (ppn_base & ~off_mask);

  always_comb begin
    res_padr  = form_padr;
    res_fault = FLT_NONE;
    if (!s1_xlat_q) begin
      res_padr = s1_vadr_q;
    end else if (!s1_hit_q) begin
      res_fault = FLT_MISS;
      res_padr  = '0;
    end else if (s1_sz_q == 2'd3) begin
      res_fault = FLT_SIZE;
    end else if ((s1_acc_q & ~s1_perm_q) != 3'b000) begin
      res_fault = FLT_PERM;
    end
  end

  // -------------------------------------------------------------------------
  // S2 registers: the response
  // -------------------------------------------------------------------------
  logic [PAW-1:0]  padr_q,  padr_d;
  logic            padrv_q, padrv_d;
  logic [1:0]      fault_q, fault_d;
  logic [CNTW-1:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    s2_v_d  = s2_v_q;
    padr_d  = padr_q;
    padrv_d = padrv_q;
    fault_d = fault_q;
    if (flush) begin
      s2_v_d = 1'b0;
    end else if (s2_adv) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        padr_d  = res_padr;
        padrv_d = (res_fault == FLT_NONE);
        fault_d = res_fault;
      end
    end
  end

  // The counter follows delivered responses only, so a miss handshaking in
  // a flush cycle still counts and flush never clears it.
  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (rsp_fire && (fault_q == FLT_MISS) && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_v_q     <= 1'b0;
      padr_q     <= '0;
      padrv_q    <= 1'b0;
      fault_q    <= FLT_NONE;
      miss_cnt_q <= '0;
    end else begin
      s2_v_q     <= s2_v_d;
      padr_q     <= padr_d;
      padrv_q    <= padrv_d;
      fault_q    <= fault_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign rsp_v    = s2_v_q;
  assign padr     = padr_q;
  assign padrv    = padrv_q;
  assign fault    = fault_q;
  assign miss_cnt = miss_cnt_q;

endmodule
